// File: rtl/pcq_trace_pkg.sv
// pcq_trace_pkg: shared definitions for the PC debug trace capture block.
//   - capture FSM state encodings (also driven on cap_state)
//   - coretrace_ctrls bit indices
//   - trace entry layout and width
// Optional build macro: PCQ_TRACE_CAPTURE_TIMESTAMP_EN adds an 8-bit
// timestamp in front of every entry (ENTRY_W 36 -> 44).
package pcq_trace_pkg;

  localparam logic [2:0] ST_IDLE  = 3'b000;
  localparam logic [2:0] ST_ARMED = 3'b001;
  localparam logic [2:0] ST_POST  = 3'b010;
  localparam logic [2:0] ST_DONE  = 3'b011;

  localparam int CT_VALID   = 0;
  localparam int CT_SB_LO   = 1;
  localparam int CT_SB_HI   = 2;
  localparam int CT_EXTSTOP = 3;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 4;

`ifdef PCQ_TRACE_CAPTURE_TIMESTAMP_EN
  localparam int TS_W = 8;
`else
  localparam int TS_W = 0;
`endif

  // Entry layout, index 0 first: [timestamp][ctrls 0:3][data 0:31]
  localparam int ENTRY_W        = TS_W + CTRL_W + DATA_W;
  localparam int ENTRY_CTRL_OFS = TS_W;
  localparam int ENTRY_DATA_OFS = TS_W + CTRL_W;

endpackage

// File: rtl/pcq_trace_buf.sv
// pcq_trace_buf: DEPTH x W trace storage, one write port, one registered
// read port (data appears the cycle after re).
// Ports:
//   clk          clock
//   we/waddr/wdata  write port
//   re/raddr     read request
//   rdata        registered read data
module pcq_trace_buf #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int W     = 36
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [0:W-1]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [0:W-1]  rdata
);

  logic [0:W-1] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pcq_trace_capture.sv
// pcq_trace_capture: receive endpoint of the PC debug trace bus. Stores valid
// samples in a circular buffer, stops on a data-compare or external-stop
// trigger plus a post-trigger count, then serves entries over rd_req/rd_ack.
// Optional build macro: PCQ_TRACE_CAPTURE_TIMESTAMP_EN (8-bit stamp per entry).
// Ports:
//   nclk, rst            clock, synchronous active-high reset
//   debug_bus_in         trace data word
//   coretrace_ctrls_in   [0]=valid, [1:2]=sideband, [3]=external stop
//   cfg_*                arm/disarm pulses, trigger compare, post count
//   rd_req               read next entry
//   rd_ack/rd_data/rd_last/rd_err  one-cycle read response
//   cap_state/cap_done/cap_wrapped/cap_trig_addr  capture status
//
// state | meaning
// IDLE  | no capture, reads return rd_err
// ARMED | storing valid samples, watching for the trigger
// POST  | storing the post-trigger samples, triggers ignored
// DONE  | capture frozen, buffer readable
module pcq_trace_capture
  import pcq_trace_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic               nclk,
  input  logic               rst,
  input  logic [0:31]        debug_bus_in,
  input  logic [0:3]         coretrace_ctrls_in,
  input  logic               cfg_arm,
  input  logic               cfg_disarm,
  input  logic [0:31]        cfg_cmp_val,
  input  logic [0:31]        cfg_cmp_mask,
  input  logic               cfg_ext_stop_en,
  input  logic [AW-1:0]      cfg_post_cnt,
  input  logic               rd_req,
  output logic               rd_ack,
  output logic [0:ENTRY_W-1] rd_data,
  output logic               rd_last,
  output logic               rd_err,
  output logic [2:0]         cap_state,
  output logic               cap_done,
  output logic               cap_wrapped,
  output logic [AW-1:0]      cap_trig_addr
);

  logic [2:0]         state, state_nxt;
  logic [AW-1:0]      wptr, wptr_nxt, rptr, post_cnt;
  logic [AW:0]        rd_count;
  logic               wrapped_nxt;
  logic               sample_valid, cmp_hit, trig, capturing, wr_en;
  logic               arm_go, enter_done, rd_ok;
  logic [0:ENTRY_W-1] wr_entry, buf_rdata;

  assign sample_valid = coretrace_ctrls_in[CT_VALID];
  // An all-zero mask would match everything, so it disables the compare.
  assign cmp_hit   = sample_valid && (cfg_cmp_mask != '0) &&
                     (((debug_bus_in ^ cfg_cmp_val) & cfg_cmp_mask) == '0);
  assign trig      = cmp_hit || (cfg_ext_stop_en && coretrace_ctrls_in[CT_EXTSTOP]);
  assign capturing = !cfg_disarm && (state == ST_ARMED || state == ST_POST);
  assign wr_en     = capturing && sample_valid;
  assign arm_go    = !cfg_disarm && cfg_arm && (state == ST_IDLE || state == ST_DONE);

  assign wptr_nxt    = arm_go ? '0 : (wr_en ? wptr + AW'(1) : wptr);
  assign wrapped_nxt = !arm_go && (cap_wrapped || (wr_en && wptr == AW'(DEPTH-1)));
  assign enter_done  = (state != ST_DONE) && (state_nxt == ST_DONE);
  assign rd_ok       = rd_req && (state == ST_DONE) && (rd_count != '0);

  always_comb begin
    state_nxt = state;
    if (cfg_disarm) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (cfg_arm) state_nxt = ST_ARMED;
        ST_ARMED: if (trig) state_nxt = (cfg_post_cnt == '0) ? ST_DONE : ST_POST;
        ST_POST:  if (wr_en && post_cnt == AW'(1)) state_nxt = ST_DONE;
        ST_DONE:  if (cfg_arm) state_nxt = ST_ARMED;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge nclk) begin
    if (rst) begin
      state         <= ST_IDLE;
      wptr          <= '0;
      rptr          <= '0;
      post_cnt      <= '0;
      rd_count      <= '0;
      cap_wrapped   <= 1'b0;
      cap_trig_addr <= '0;
      rd_ack        <= 1'b0;
      rd_err        <= 1'b0;
      rd_last       <= 1'b0;
    end else begin
      state       <= state_nxt;
      wptr        <= wptr_nxt;
      cap_wrapped <= wrapped_nxt;

      if (capturing && state == ST_ARMED && trig) begin
        cap_trig_addr <= wptr;
        post_cnt      <= cfg_post_cnt;
      end else if (wr_en && state == ST_POST) begin
        post_cnt <= post_cnt - AW'(1);
      end

      // Once wrapped, the oldest surviving entry sits at the write pointer.
      if (enter_done) begin
        rptr     <= wrapped_nxt ? wptr_nxt : '0;
        rd_count <= wrapped_nxt ? (AW+1)'(DEPTH) : {1'b0, wptr_nxt};
      end else if (rd_ok) begin
        rptr     <= rptr + AW'(1);
        rd_count <= rd_count - (AW+1)'(1);
      end

      rd_ack  <= rd_req;
      rd_err  <= rd_req && !rd_ok;
      rd_last <= rd_ok && (rd_count == (AW+1)'(1));
    end
  end

`ifdef PCQ_TRACE_CAPTURE_TIMESTAMP_EN
  logic [7:0] ts_cnt;

  always_ff @(posedge nclk) begin
    if (rst)                                          ts_cnt <= '0;
    else if (arm_go)                                  ts_cnt <= '0;
    else if (state == ST_ARMED || state == ST_POST)   ts_cnt <= ts_cnt + 8'd1;
  end

  // Stamp counts capture cycles since arm, including the current one.
  assign wr_entry = {ts_cnt + 8'd1, coretrace_ctrls_in, debug_bus_in};
`else
  assign wr_entry = {coretrace_ctrls_in, debug_bus_in};
`endif

  pcq_trace_buf #(.DEPTH(DEPTH), .AW(AW), .W(ENTRY_W)) u_buf (
    .clk   (nclk),
    .we    (wr_en),
    .waddr (wptr),
    .wdata (wr_entry),
    .re    (rd_ok),
    .raddr (rptr),
    .rdata (buf_rdata)
  );

  assign rd_data   = (rd_ack && !rd_err) ? buf_rdata : '0;
  assign cap_state = state;
  assign cap_done  = (state == ST_DONE);

endmodule

// File: tb/tb_pcq_trace_capture.sv
module tb_pcq_trace_capture;
  import pcq_trace_pkg::*;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic               nclk = 1'b0;
  logic               rst;
  logic [0:31]        debug_bus_in;
  logic [0:3]         coretrace_ctrls_in;
  logic               cfg_arm, cfg_disarm;
  logic [0:31]        cfg_cmp_val, cfg_cmp_mask;
  logic               cfg_ext_stop_en;
  logic [AW-1:0]      cfg_post_cnt;
  logic               rd_req;
  logic               rd_ack;
  logic [0:ENTRY_W-1] rd_data;
  logic               rd_last, rd_err;
  logic [2:0]         cap_state;
  logic               cap_done, cap_wrapped;
  logic [AW-1:0]      cap_trig_addr;

  pcq_trace_capture #(.DEPTH(DEPTH), .AW(AW)) dut (
    .nclk(nclk), .rst(rst), .debug_bus_in(debug_bus_in),
    .coretrace_ctrls_in(coretrace_ctrls_in), .cfg_arm(cfg_arm),
    .cfg_disarm(cfg_disarm), .cfg_cmp_val(cfg_cmp_val),
    .cfg_cmp_mask(cfg_cmp_mask), .cfg_ext_stop_en(cfg_ext_stop_en),
    .cfg_post_cnt(cfg_post_cnt), .rd_req(rd_req), .rd_ack(rd_ack),
    .rd_data(rd_data), .rd_last(rd_last), .rd_err(rd_err),
    .cap_state(cap_state), .cap_done(cap_done), .cap_wrapped(cap_wrapped),
    .cap_trig_addr(cap_trig_addr)
  );

  always #5 nclk = ~nclk;

  typedef struct packed {
    logic        err;
    logic        last;
    logic [35:0] data;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: phase 0 idle, 1 armed, 2 post, 3 done.
  int          m_phase = 0;
  int          m_total = 0;     // samples stored since arm
  int          m_left  = 0;
  int          m_trig  = 0;
  logic [35:0] m_store[$];      // most recent DEPTH samples
  logic [35:0] m_rdq[$];        // entries still to be read out

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic finish_capture();
    m_phase = 3;
    m_rdq   = m_store;
  endtask

  task automatic store_sample(input logic [35:0] ent);
    m_store.push_back(ent);
    if (m_store.size() > DEPTH) void'(m_store.pop_front());
    m_total++;
  endtask

  task automatic check_status();
    chk("cap_state",     64'(cap_state),     64'(m_phase));
    chk("cap_done",      64'(cap_done),      64'(m_phase == 3));
    chk("cap_wrapped",   64'(cap_wrapped),   64'(m_total >= DEPTH));
    chk("cap_trig_addr", 64'(cap_trig_addr), 64'(m_trig));
  endtask

  task automatic step(input logic arm, input logic disarm, input logic [0:3] ct,
                      input logic [31:0] d, input logic rd);
    exp_t e;
    logic have_e;
    logic valid, hit, trig;
    e = '0;
    have_e = 1'b0;
    cfg_arm = arm; cfg_disarm = disarm;
    coretrace_ctrls_in = ct; debug_bus_in = d; rd_req = rd;

    if (rd) begin
      have_e = 1'b1;
      if (m_phase == 3 && m_rdq.size() != 0) begin
        e.err  = 1'b0;
        e.last = (m_rdq.size() == 1);
        e.data = m_rdq.pop_front();
      end else begin
        e.err = 1'b1; e.last = 1'b0; e.data = '0;
      end
    end

    valid = ct[0];
    hit   = valid && (cfg_cmp_mask != 0) && ((d & cfg_cmp_mask) == (cfg_cmp_val & cfg_cmp_mask));
    trig  = hit || (cfg_ext_stop_en && ct[3]);
    if (disarm) begin
      m_phase = 0;
    end else if (arm && (m_phase == 0 || m_phase == 3)) begin
      m_phase = 1; m_total = 0; m_store.delete();
    end else if (m_phase == 1) begin
      if (trig) m_trig = m_total % DEPTH;
      if (valid) store_sample({ct, d});
      if (trig) begin
        if (cfg_post_cnt == 0) finish_capture();
        else begin m_phase = 2; m_left = int'(cfg_post_cnt); end
      end
    end else if (m_phase == 2 && valid) begin
      store_sample({ct, d});
      m_left--;
      if (m_left == 0) finish_capture();
    end

    @(posedge nclk);
    if (have_e) expq.push_back(e);
    #1;
    check_status();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'b0000, 32'h0, 1'b0);
  endtask

  task automatic do_reset(input logic rd);
    rst = 1'b1; rd_req = rd; cfg_arm = 1'b0; cfg_disarm = 1'b0;
    coretrace_ctrls_in = 4'b0000; debug_bus_in = '0;
    @(posedge nclk); #1;
    rst = 1'b0; rd_req = 1'b0;
    m_phase = 0; m_total = 0; m_trig = 0; m_left = 0;
    m_store.delete(); m_rdq.delete();
    chk("rst_rd_ack",  64'(rd_ack),  64'd0);
    chk("rst_rd_err",  64'(rd_err),  64'd0);
    chk("rst_rd_last", 64'(rd_last), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    check_status();
  endtask

  // Monitor: every rd_req is answered exactly one cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge nclk);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        total++;
        if (rd_ack !== 1'b1 || rd_err !== e.err || rd_last !== e.last ||
            rd_data[ENTRY_W-36 +: 36] !== e.data) begin
          bad++;
          $display("FAIL rd_resp actual ack=%0b err=%0b last=%0b data=%09h required ack=1 err=%0b last=%0b data=%09h",
                   rd_ack, rd_err, rd_last, rd_data[ENTRY_W-36 +: 36], e.err, e.last, e.data);
        end
      end else if (rd_ack === 1'b1) begin
        total++; bad++;
        $display("FAIL rd_ack_unexpected actual=1 required=0");
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:3] ct;
    cfg_cmp_val = '0; cfg_cmp_mask = '0; cfg_ext_stop_en = 1'b0; cfg_post_cnt = '0;
    cfg_arm = 1'b0; cfg_disarm = 1'b0; rd_req = 1'b0;
    coretrace_ctrls_in = '0; debug_bus_in = '0;
    do_reset(1'b0);
    idle(2);

    // Compare trigger on 0x5, two post samples, no wrap
    cfg_cmp_mask = 32'hFFFF_FFFF; cfg_cmp_val = 32'h5; cfg_post_cnt = 5'd2;
    step(1'b1, 1'b0, 4'b0000, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 4'b1000, 32'(i), 1'b0);
    chk("t1_trig_addr", 64'(cap_trig_addr), 64'd5);
    chk("t1_state_done", 64'(cap_state), 64'(ST_DONE));
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 4'b0000, 32'h0, 1'b1);
    idle(2);

    // Trigger on the 40th sample, wrap
    cfg_cmp_val = 32'd39; cfg_post_cnt = 5'd3;
    step(1'b1, 1'b0, 4'b0000, 32'h0, 1'b0);
    for (int i = 0; i < 45; i++) step(1'b0, 1'b0, 4'b1110, 32'(i), 1'b0);
    chk("t2_wrapped", 64'(cap_wrapped), 64'd1);
    chk("t2_trig_addr", 64'(cap_trig_addr), 64'd7);
    for (int i = 0; i < 33; i++) step(1'b0, 1'b0, 4'b0000, 32'h0, 1'b1);
    idle(2);

    // External stop with valid=0, immediate DONE
    cfg_cmp_mask = '0; cfg_ext_stop_en = 1'b1; cfg_post_cnt = 5'd0;
    step(1'b1, 1'b0, 4'b0000, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b1000, 32'hA0 + 32'(i), 1'b0);
    step(1'b0, 1'b0, 4'b0001, 32'hDEAD, 1'b0);
    chk("t3_trig_addr", 64'(cap_trig_addr), 64'd3);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'b0000, 32'h0, 1'b1);
    idle(1);

    // Arm+disarm together from IDLE, then disarm during POST
    step(1'b0, 1'b1, 4'b0000, 32'h0, 1'b0);
    step(1'b1, 1'b1, 4'b1000, 32'h1, 1'b0);
    chk("t4_stay_idle", 64'(cap_state), 64'(ST_IDLE));
    cfg_post_cnt = 5'd5;
    step(1'b1, 1'b0, 4'b0000, 32'h0, 1'b0);
    step(1'b0, 1'b0, 4'b1001, 32'h2, 1'b0);
    step(1'b0, 1'b0, 4'b1000, 32'h3, 1'b0);
    step(1'b0, 1'b1, 4'b1000, 32'h4, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 32'h0, 1'b1);
    idle(1);

    // Reset in POST with a read pending, then a fresh capture
    step(1'b1, 1'b0, 4'b0000, 32'h0, 1'b0);
    step(1'b0, 1'b0, 4'b1001, 32'h7, 1'b0);
    step(1'b0, 1'b0, 4'b1000, 32'h8, 1'b0);
    do_reset(1'b1);
    idle(1);
    cfg_ext_stop_en = 1'b0; cfg_cmp_mask = 32'hFF; cfg_cmp_val = 32'h33; cfg_post_cnt = 5'd1;
    step(1'b1, 1'b0, 4'b0000, 32'h0, 1'b0);
    step(1'b0, 1'b0, 4'b1000, 32'h11, 1'b0);
    step(1'b0, 1'b0, 4'b1000, 32'h133, 1'b0);
    step(1'b0, 1'b0, 4'b1000, 32'h44, 1'b0);
    chk("t5_trig_addr", 64'(cap_trig_addr), 64'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'b0000, 32'h0, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      logic arm, dis, rd;
      arm = ($urandom_range(0, 19) == 0);
      dis = ($urandom_range(0, 99) == 0);
      rd  = ($urandom_range(0, 2) == 0);
      if (arm) begin
        cfg_cmp_mask    = ($urandom_range(0, 3) == 0) ? 32'hFF : 32'h0F;
        cfg_cmp_val     = 32'($urandom_range(0, 15));
        cfg_ext_stop_en = $urandom_range(0, 1) == 1;
        cfg_post_cnt    = AW'($urandom_range(0, DEPTH-1));
      end
      ct[0] = ($urandom_range(0, 3) != 0);
      ct[1] = $urandom_range(0, 1) == 1;
      ct[2] = $urandom_range(0, 1) == 1;
      ct[3] = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 599) == 0) do_reset(rd);
      else step(arm, dis, ct, 32'($urandom_range(0, 255)), rd);
    end

    idle(3);
    chk("ack_queue_drained", 64'(expq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcq_trace_capture.md
Name: pcq_trace_capture

Overview:
- Receive-side endpoint of the PC debug trace bus: consumes the registered 32-bit trace word and 4-bit coretrace controls driven by the pcq debug mux chain.
- Records samples into a circular trace buffer and stops on a programmable data-compare trigger or an external stop, after a configurable post-trigger count.
- Captured data is read out through a serial req/ack port used by the SCOM/register layer.

Parameters:
DEPTH, 32, trace buffer entries; must be a power of 2, minimum 4
AW, 5, address width, log2(DEPTH)
ENTRY_W, 36, entry width {ctrls[0:3], data[0:31]}; 44 when the timestamp feature is compiled in

Ports:
nclk  in  1  clock; single clock domain
rst  in  1  reset, synchronous, active-high
debug_bus_in  in  32  trace data word [0:31]
coretrace_ctrls_in  in  4  [0]=sample valid, [1:2]=sideband (stored only), [3]=external stop
cfg_arm  in  1  pulse: start a capture
cfg_disarm  in  1  pulse: abort, go to IDLE
cfg_cmp_val  in  32  trigger compare value
cfg_cmp_mask  in  32  trigger compare mask; 1 = bit compared
cfg_ext_stop_en  in  1  enables coretrace_ctrls_in[3] as trigger
cfg_post_cnt  in  AW  samples stored after the trigger sample
rd_req  in  1  pulse: read next entry
rd_ack  out  1  one-cycle response to rd_req
rd_data  out  ENTRY_W  entry read
rd_last  out  1  with rd_ack: this is the final valid entry
rd_err  out  1  with rd_ack: read not allowed or buffer exhausted
cap_state  out  3  current FSM state encoding
cap_done  out  1  capture complete
cap_wrapped  out  1  buffer wrapped during capture
cap_trig_addr  out  AW  buffer address of the trigger sample

Behaviour:
- Reset: FSM=IDLE. wptr, rptr, post counter, rd_count and all outputs are 0. Buffer contents are undefined and not read out.
- A sample is valid when coretrace_ctrls_in[0]=1. Entry format: {coretrace_ctrls_in, debug_bus_in}.
- Trigger: valid & (cfg_cmp_mask != 0) & (((debug_bus_in ^ cfg_cmp_val) & cfg_cmp_mask) == 0), OR (cfg_ext_stop_en & coretrace_ctrls_in[3]). coretrace_ctrls_in[3] alone, without valid, still triggers; that cycle writes no entry.
- States:
  - IDLE=000: cfg_arm -> ARMED. On arm: wptr=0, cap_wrapped=0, cap_done=0.
  - ARMED=001: each valid sample is written at wptr, then wptr=(wptr+1) mod DEPTH. Wrapping from DEPTH-1 to 0 sets cap_wrapped. On trigger: write the sample if valid, cap_trig_addr=wptr (the pre-increment address), load post counter=cfg_post_cnt. Go to DONE if cfg_post_cnt=0, else POST. The trigger is not evaluated in the arm cycle itself.
  - POST=010: each valid sample is written and decrements the counter. The write that brings the counter to 0 moves the FSM to DONE next cycle. Triggers are ignored. Maximum cfg_post_cnt=DEPTH-1, so the trigger entry is never overwritten.
  - DONE=011: cap_done=1, no writes. On entry: rptr = cap_wrapped ? wptr : 0, and rd_count = cap_wrapped ? DEPTH : wptr.
- Readout:
  - rd_req in DONE with rd_count>0: rd_ack=1 the next cycle, rd_data=buf[rptr], rptr++, rd_count--. rd_last=1 when rd_count was 1.
  - rd_req in any other state, or with rd_count=0: rd_ack=1, rd_err=1, rd_data=0.
  - rd_req while rd_ack is high is accepted; back-to-back reads run 1 per cycle.
- Priority: rst > cfg_disarm > cfg_arm > trigger/write.
  - Disarm in any state -> IDLE next cycle; a sample in that cycle is not written.
  - cfg_arm in DONE restarts the capture as from IDLE.
  - cfg_arm in ARMED or POST is ignored.
- Reset mid-capture or mid-read returns to IDLE. No rd_ack is issued for a pending rd_req.
- Buffer writes take 1 cycle; buffer reads are registered, 1-cycle latency.

Optional Feature:
- Macro: PCQ_TRACE_CAPTURE_TIMESTAMP_EN.
- Defined:
  - 8-bit counter cleared on arm, incremented every cycle while ARMED or POST, wrapping at 255.
  - Each entry is prefixed with the counter value, so ENTRY_W=44 and rd_data[0:7] is the timestamp.
- Not defined: no counter, ENTRY_W=36.

Decomposition:
- Shared package pcq_trace_pkg:
  - state encoding constants (IDLE/ARMED/POST/DONE)
  - coretrace_ctrls bit-index constants (VALID=0, SB=1:2, EXTSTOP=3)
  - entry field offsets and ENTRY_W
- One sub-module, pcq_trace_buf: DEPTH x ENTRY_W storage with one write port and one registered read port.

Test Plan:
- Arm, then 10 valid samples with data 0x0..0x9; mask=0xFFFFFFFF, val=0x5, post_cnt=2 -> DONE after sample 0x7; cap_trig_addr=5; 8 reads return 0x0..0x7; rd_last on the 8th read; a 9th read gives rd_err=1.
- DEPTH=32, post_cnt=3, trigger on the 40th sample (data 39) -> cap_wrapped=1; 32 reads return data 11..42 in order.
- ext_stop_en=1 and coretrace_ctrls_in=4'b0001 with valid=0 in ARMED -> trigger, no entry written, cap_trig_addr=wptr.
- cfg_arm and cfg_disarm in the same cycle from IDLE -> stays IDLE. Disarm during POST -> IDLE; rd_req then returns rd_err=1.
- rst asserted in POST with rd_req pending -> all outputs 0 the next cycle, no rd_ack. A new arm captures normally.
- With PCQ_TRACE_CAPTURE_TIMESTAMP_EN: samples on cycles 3, 4 and 10 after arm -> rd_data[0:7]=3, 4, 10.
